jtag_tap_responder: RTL and testbench
=====================================

// Module: jtag_tap_responder
// PURPOSE
//  - Target-side JTAG TAP for simulation harnesses; the responder to the DPI-driven JTAG master.
//  - Oversamples jtag_TCK/TMS/TDI/TRSTn in the system clock domain. No separate TCK clock.
//  - Implements the IEEE 1149.1 16-state TAP FSM, a 5-bit IR, and the IDCODE, BYPASS and USER_DR data registers.
//  - Drives jtag_TDO_data/jtag_TDO_driven back to the master.
//  - USER_DR is exposed as a capture/update interface for a downstream debug module.
// PARAMETERS
//  IR_WIDTH       5             instruction register width, >=2
//  IDCODE_VALUE   32'h20000913  returned by IDCODE; bit0 must be 1
//  USER_DR_WIDTH  32            width of USER_DR, >=1
//  USER_DR_IR     5'h11         IR code selecting USER_DR
// PORTS
//  clock               in   1   system clock; all state updates on posedge
//  reset               in   1   synchronous, active-high reset
//  jtag_TCK            in   1   JTAG clock, sampled as data
//  jtag_TMS            in   1   test mode select
//  jtag_TDI            in   1   test data in
//  jtag_TRSTn          in   1   test reset, active low, sampled
//  jtag_TDO_data       out  1   test data out
//  jtag_TDO_driven     out  1   high while TDO is valid (Shift-IR/Shift-DR)
//  user_capture_data   in   USER_DR_WIDTH  value loaded into USER_DR at Capture-DR
//  user_capture_strobe out  1   1-clock pulse when USER_DR captures
//  user_update_valid   out  1   1-clock pulse at Update-DR with USER_DR selected
//  user_update_data    out  USER_DR_WIDTH  shifted-in value, held until next update
//  tap_state           out  4   current TAP state encoding, for debug
//  ir_value            out  IR_WIDTH       current (updated) instruction
// BEHAVIOUR
//  - Input sampling
//    - All four jtag_* inputs are registered once: tck_q, tms_q, tdi_q, trstn_q.
//    - tck_rise = tck_q & ~tck_prev; tck_fall = ~tck_q & tck_prev. These are mutually exclusive.
//  - Reset
//    - On reset: state=TEST_LOGIC_RESET; IR=IDCODE (5'h01); shift registers=0.
//    - All outputs reset to 0, except tap_state=TLR and ir_value=5'h01. tck_prev resets to 0.
//  - TRSTn
//    - While trstn_q==0, the next clock forces the same state as reset, except input/edge registers.
//    - TRSTn overrides any coincident TCK edge.
//  - TAP FSM
//    - Advances only on tck_rise, using tms_q, per 1149.1.
//    - Transitions:
//      - TLR -> RTI on TMS=0.
//      - RTI -> SelDR on TMS=1.
//      - SelDR -> CapDR on 0, SelIR on 1.
//      - SelIR -> CapIR on 0, TLR on 1.
//      - Cap -> Shift on 0, Exit1 on 1.
//      - Shift stays on 0, Exit1 on 1.
//      - Exit1 -> Pause on 0, Update on 1.
//      - Pause stays on 0, Exit2 on 1.
//      - Exit2 -> Shift on 0, Update on 1.
//      - Update -> RTI on 0, SelDR on 1.
//    - 5x TMS=1 from any state reaches TLR. Entering TLR loads IR=IDCODE.
//  - Capture (tck_rise while in CapIR/CapDR)
//    - IR shift register <= {0..0,2'b01}.
//    - DR shift register is loaded per IR:
//      - IDCODE: IDCODE_VALUE.
//      - USER_DR: user_capture_data, and user_capture_strobe pulses.
//      - BYPASS and any unknown IR: 1'b0.
//  - Shift (tck_rise while in ShiftIR/ShiftDR)
//    - sr <= {tdi_q, sr[W-1:1]}, where W is the width of the selected register.
//    - LSB goes out first.
//  - TDO (updated on tck_fall only)
//    - jtag_TDO_data <= sr[0] of the active register.
//    - jtag_TDO_driven <= (state==ShiftIR | state==ShiftDR).
//    - Both outputs hold between falling edges.
//  - Update (tck_fall while in UpdateIR/UpdateDR)
//    - UpdateIR: IR <= IR shift register.
//    - UpdateDR with IR==USER_DR_IR:
//      - user_update_data <= USER_DR shift register.
//      - user_update_valid pulses for exactly 1 clock.
//    - Pause/Exit paths preserve shift contents.
//  - Latency
//    - TCK edge to state/shift change: 2 clocks (input register + edge detect).
//    - TCK edge to TDO change: 2 clocks.
//  - Reset or TRSTn mid-shift
//    - Partial data is discarded.
//    - No update pulse is produced.
// STRUCTURE
//  - Package jtag_tap_pkg holds:
//    - tap_state_e, the 4-bit enum of the 16 states.
//    - IR code constants: IDCODE=5'h01, BYPASS=5'h1F.
//    - Capture-IR pattern.
//  - One sub-module, jtag_tap_fsm: state register plus next-state function.
//    - Inputs: clock, reset, trstn, tck_rise, tms.
//  - The top level holds input regs, edge detect, IR/DR shift registers, TDO and the user interface.
// TESTING
//  1. Reset; shift 32 DR bits with TDI=0 -> TDO LSB-first = 32'h20000913; driven=1 only during ShiftDR.
//  2. IR scan shifting in 5'h1F -> TDO shows 5'b00001 captured; ir_value=5'h1F after UpdateIR; then DR-shift 8 bits 0xA5 -> TDO = 0 followed by 0xA5 delayed 1 TCK.
//  3. IR=5'h11, user_capture_data=32'hDEADBEEF, shift in 32'h12345678 -> TDO yields DEADBEEF; capture_strobe pulses once; after UpdateDR, user_update_valid pulses once with 32'h12345678.
//  4. TRSTn=0 for one TCK period mid ShiftDR (USER_DR) -> tap_state=TLR, ir_value=5'h01, driven=0, no user_update_valid.
//  5. reset asserted mid ShiftIR, then TMS=0 + one TCK -> state RTI, IR=IDCODE, all outputs at reset values.
//  6. TCK held constant for 20 clocks while TMS/TDI toggle -> no change in tap_state, shift registers or TDO.

Source files
------------

// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: shared TAP state encoding, instruction codes and next-state function
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR   = 4'h0,
        EXIT1_DR   = 4'h1,
        SHIFT_DR   = 4'h2,
        PAUSE_DR   = 4'h3,
        SELECT_IR  = 4'h4,
        UPDATE_DR  = 4'h5,
        CAPTURE_DR = 4'h6,
        SELECT_DR  = 4'h7,
        EXIT2_IR   = 4'h8,
        EXIT1_IR   = 4'h9,
        SHIFT_IR   = 4'hA,
        PAUSE_IR   = 4'hB,
        RTI        = 4'hC,
        UPDATE_IR  = 4'hD,
        CAPTURE_IR = 4'hE,
        TLR        = 4'hF
    } tap_state_e;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_BYPASS = 5'h1F;
    localparam logic [1:0] IR_CAPTURE = 2'b01;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        case (s)
            TLR:        return tms ? TLR : RTI;
            RTI:        return tms ? SELECT_DR : RTI;
            SELECT_DR:  return tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR: return tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR:   return tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR:   return tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   return tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR:   return tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:  return tms ? SELECT_DR : RTI;
            SELECT_IR:  return tms ? TLR : CAPTURE_IR;
            CAPTURE_IR: return tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR:   return tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR:   return tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   return tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR:   return tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:  return tms ? SELECT_DR : RTI;
            default:    return TLR;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state TAP controller advancing on detected TCK rising edges
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       trstn,
    input  logic       tck_rise,
    input  logic       tms,
    output tap_state_e state
);

    // TRSTn wins over a coincident TCK edge
    always_ff @(posedge clock) begin
        if (reset || !trstn) state <= TLR;
        else if (tck_rise)   state <= tap_next(state, tms);
    end

endmodule

// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder: oversampled JTAG TAP with IDCODE, BYPASS and a user data register
module jtag_tap_responder
    import jtag_tap_pkg::*;
#(
    parameter int                  IR_WIDTH      = 5,
    parameter logic [31:0]         IDCODE_VALUE  = 32'h20000913,
    parameter int                  USER_DR_WIDTH = 32,
    parameter logic [IR_WIDTH-1:0] USER_DR_IR    = IR_WIDTH'(5'h11)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     jtag_TCK,
    input  logic                     jtag_TMS,
    input  logic                     jtag_TDI,
    input  logic                     jtag_TRSTn,
    output logic                     jtag_TDO_data,
    output logic                     jtag_TDO_driven,
    input  logic [USER_DR_WIDTH-1:0] user_capture_data,
    output logic                     user_capture_strobe,
    output logic                     user_update_valid,
    output logic [USER_DR_WIDTH-1:0] user_update_data,
    output logic [3:0]               tap_state,
    output logic [IR_WIDTH-1:0]      ir_value
);

    localparam int DRW = (USER_DR_WIDTH > 32) ? USER_DR_WIDTH : 32;
    localparam int DRI = $clog2(DRW);
    localparam logic [IR_WIDTH-1:0] IDC = IR_WIDTH'(IR_IDCODE);

    logic                tck_q, tck_prev_q, tms_q, tdi_q, trstn_q;
    logic                tck_rise, tck_fall;
    tap_state_e          state;
    logic [IR_WIDTH-1:0] ir_q, ir_sr_q;
    logic [DRW-1:0]      dr_sr_q, dr_d;
    logic [DRI-1:0]      dr_msb;

    assign tck_rise  = tck_q & ~tck_prev_q;
    assign tck_fall  = ~tck_q & tck_prev_q;
    assign tap_state = state;
    assign ir_value  = ir_q;

    // Single-stage input sampling plus TCK history for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            tck_q      <= 1'b0;
            tck_prev_q <= 1'b0;
            tms_q      <= 1'b0;
            tdi_q      <= 1'b0;
            trstn_q    <= 1'b1;
        end else begin
            tck_q      <= jtag_TCK;
            tck_prev_q <= tck_q;
            tms_q      <= jtag_TMS;
            tdi_q      <= jtag_TDI;
            trstn_q    <= jtag_TRSTn;
        end
    end

    jtag_tap_fsm u_fsm (
        .clock    (clock),
        .reset    (reset),
        .trstn    (trstn_q),
        .tck_rise (tck_rise),
        .tms      (tms_q),
        .state    (state)
    );

    // DR shift inserts TDI at the MSB of whichever register the IR selects
    always_comb begin
        dr_msb = (ir_q == IDC) ? DRI'(31) : (ir_q == USER_DR_IR) ? DRI'(USER_DR_WIDTH - 1) : '0;
        dr_d = dr_sr_q >> 1;
        dr_d[dr_msb] = tdi_q;
    end

    // Capture/shift on TCK rise, TDO and update on TCK fall
    always_ff @(posedge clock) begin
        if (reset || !trstn_q) begin
            ir_q                <= IDC;
            ir_sr_q             <= '0;
            dr_sr_q             <= '0;
            jtag_TDO_data       <= 1'b0;
            jtag_TDO_driven     <= 1'b0;
            user_capture_strobe <= 1'b0;
            user_update_valid   <= 1'b0;
            user_update_data    <= '0;
        end else begin
            user_capture_strobe <= 1'b0;
            user_update_valid   <= 1'b0;
            if (state == TLR) ir_q <= IDC;
            if (tck_rise) begin
                if (state == CAPTURE_IR) ir_sr_q <= IR_WIDTH'(IR_CAPTURE);
                if (state == SHIFT_IR) ir_sr_q <= {tdi_q, ir_sr_q[IR_WIDTH-1:1]};
                if (state == SHIFT_DR) dr_sr_q <= dr_d;
                if (state == CAPTURE_DR) begin
                    dr_sr_q <= (ir_q == IDC) ? DRW'(IDCODE_VALUE) :
                               (ir_q == USER_DR_IR) ? DRW'(user_capture_data) : '0;
                    user_capture_strobe <= (ir_q == USER_DR_IR);
                end
            end
            if (tck_fall) begin
                jtag_TDO_data   <= (state == SHIFT_IR) ? ir_sr_q[0] : dr_sr_q[0];
                jtag_TDO_driven <= (state == SHIFT_IR) || (state == SHIFT_DR);
                if (state == UPDATE_IR) ir_q <= ir_sr_q;
                if (state == UPDATE_DR && ir_q == USER_DR_IR) begin
                    user_update_data  <= dr_sr_q[USER_DR_WIDTH-1:0];
                    user_update_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_responder.sv
// tb_jtag_tap_responder: directed scenarios for the oversampled JTAG TAP responder
module tb_jtag_tap_responder;
    import jtag_tap_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        jtag_TCK = 1'b0, jtag_TMS = 1'b0, jtag_TDI = 1'b0, jtag_TRSTn = 1'b1;
    logic [31:0] user_capture_data = '0;
    logic        jtag_TDO_data, jtag_TDO_driven, user_capture_strobe, user_update_valid;
    logic [31:0] user_update_data;
    logic [3:0]  tap_state;
    logic [4:0]  ir_value;

    int checks = 0, errors = 0, strobe_cnt = 0, valid_cnt = 0;

    jtag_tap_responder dut (
        .clock               (clock),
        .reset               (reset),
        .jtag_TCK            (jtag_TCK),
        .jtag_TMS            (jtag_TMS),
        .jtag_TDI            (jtag_TDI),
        .jtag_TRSTn          (jtag_TRSTn),
        .jtag_TDO_data       (jtag_TDO_data),
        .jtag_TDO_driven     (jtag_TDO_driven),
        .user_capture_data   (user_capture_data),
        .user_capture_strobe (user_capture_strobe),
        .user_update_valid   (user_update_valid),
        .user_update_data    (user_update_data),
        .tap_state           (tap_state),
        .ir_value            (ir_value)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (user_capture_strobe) strobe_cnt++;
        if (user_update_valid) valid_cnt++;
    end

    task automatic tick(input logic tms, input logic tdi);
        @(negedge clock);
        jtag_TMS = tms;
        jtag_TDI = tdi;
        repeat (3) @(negedge clock);
        jtag_TCK = 1'b1;
        repeat (4) @(negedge clock);
        jtag_TCK = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic shift(input int n, input logic [31:0] din, input logic last_tms,
                         output logic [31:0] dout, output int undriven);
        dout = '0;
        undriven = 0;
        for (int i = 0; i < n; i++) begin
            dout[i] = jtag_TDO_data;
            if (jtag_TDO_driven !== 1'b1) undriven++;
            tick((i == n - 1) ? last_tms : 1'b0, din[i]);
        end
    endtask

    task automatic goto_shift_dr();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic goto_shift_ir();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic exit_update();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        checks++; if (tap_state !== 4'(TLR)) begin errors++; $display("FAIL reset_state: got %h expected %h", tap_state, 4'(TLR)); end
        checks++; if (ir_value !== 5'h01) begin errors++; $display("FAIL reset_ir: got %h expected 01", ir_value); end
        checks++; if ({jtag_TDO_data, jtag_TDO_driven, user_capture_strobe, user_update_valid} !== 4'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 0000", {jtag_TDO_data, jtag_TDO_driven, user_capture_strobe, user_update_valid}); end
        checks++; if (user_update_data !== 32'h0) begin errors++; $display("FAIL reset_update_data: got %h expected 0", user_update_data); end
    endtask

    task automatic test_idcode();
        logic [31:0] d;
        int u;
        int v0;
        v0 = valid_cnt;
        tick(1'b0, 1'b0);
        checks++; if (tap_state !== 4'(RTI)) begin errors++; $display("FAIL idcode_rti: got %h expected %h", tap_state, 4'(RTI)); end
        checks++; if (jtag_TDO_driven !== 1'b0) begin errors++; $display("FAIL idcode_driven_idle: got %b expected 0", jtag_TDO_driven); end
        goto_shift_dr();
        checks++; if (tap_state !== 4'(SHIFT_DR)) begin errors++; $display("FAIL idcode_shift_state: got %h expected %h", tap_state, 4'(SHIFT_DR)); end
        shift(32, 32'h0, 1'b1, d, u);
        checks++; if (d !== 32'h20000913) begin errors++; $display("FAIL idcode_value: got %h expected 20000913", d); end
        checks++; if (u !== 0) begin errors++; $display("FAIL idcode_driven_shift: got %0d undriven bits expected 0", u); end
        checks++; if (jtag_TDO_driven !== 1'b0) begin errors++; $display("FAIL idcode_driven_exit: got %b expected 0", jtag_TDO_driven); end
        exit_update();
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL idcode_no_update: got %0d pulses expected 0", valid_cnt - v0); end
    endtask

    task automatic test_bypass();
        logic [31:0] d;
        int u;
        goto_shift_ir();
        checks++; if (tap_state !== 4'(SHIFT_IR)) begin errors++; $display("FAIL bypass_shift_ir: got %h expected %h", tap_state, 4'(SHIFT_IR)); end
        shift(5, 32'h1F, 1'b1, d, u);
        checks++; if (d[4:0] !== 5'b00001) begin errors++; $display("FAIL bypass_ir_capture: got %b expected 00001", d[4:0]); end
        checks++; if (u !== 0) begin errors++; $display("FAIL bypass_ir_driven: got %0d undriven bits expected 0", u); end
        exit_update();
        checks++; if (ir_value !== 5'h1F) begin errors++; $display("FAIL bypass_ir_value: got %h expected 1f", ir_value); end
        goto_shift_dr();
        shift(8, 32'hA5, 1'b1, d, u);
        checks++; if (d[7:0] !== 8'h4A) begin errors++; $display("FAIL bypass_dr_delay: got %h expected 4a", d[7:0]); end
        exit_update();
    endtask

    task automatic test_user_dr();
        logic [31:0] d;
        int u;
        int s0, v0;
        goto_shift_ir();
        shift(5, 32'h11, 1'b1, d, u);
        exit_update();
        checks++; if (ir_value !== 5'h11) begin errors++; $display("FAIL user_ir_value: got %h expected 11", ir_value); end
        user_capture_data = 32'hDEADBEEF;
        s0 = strobe_cnt;
        goto_shift_dr();
        shift(32, 32'h12345678, 1'b1, d, u);
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL user_capture_tdo: got %h expected deadbeef", d); end
        checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL user_strobe_count: got %0d expected 1", strobe_cnt - s0); end
        v0 = valid_cnt;
        exit_update();
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL user_update_count: got %0d expected 1", valid_cnt - v0); end
        checks++; if (user_update_data !== 32'h12345678) begin errors++; $display("FAIL user_update_data: got %h expected 12345678", user_update_data); end
        checks++; if (tap_state !== 4'(RTI)) begin errors++; $display("FAIL user_back_rti: got %h expected %h", tap_state, 4'(RTI)); end
    endtask

    task automatic test_trst_mid_shift();
        logic [31:0] d;
        int u;
        int v0;
        v0 = valid_cnt;
        goto_shift_dr();
        shift(10, 32'h3FF, 1'b0, d, u);
        jtag_TRSTn = 1'b0;
        tick(1'b0, 1'b1);
        jtag_TRSTn = 1'b1;
        repeat (4) @(negedge clock);
        checks++; if (tap_state !== 4'(TLR)) begin errors++; $display("FAIL trst_state: got %h expected %h", tap_state, 4'(TLR)); end
        checks++; if (ir_value !== 5'h01) begin errors++; $display("FAIL trst_ir: got %h expected 01", ir_value); end
        checks++; if (jtag_TDO_driven !== 1'b0) begin errors++; $display("FAIL trst_driven: got %b expected 0", jtag_TDO_driven); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL trst_no_update: got %0d pulses expected 0", valid_cnt - v0); end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] d;
        int u;
        int v0;
        tick(1'b0, 1'b0);
        goto_shift_ir();
        shift(2, 32'h3, 1'b0, d, u);
        checks++; if (jtag_TDO_driven !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_driven: got %b expected 1", jtag_TDO_driven); end
        v0 = valid_cnt;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checks++; if (tap_state !== 4'(TLR)) begin errors++; $display("FAIL rst_mid_state: got %h expected %h", tap_state, 4'(TLR)); end
        tick(1'b0, 1'b0);
        checks++; if (tap_state !== 4'(RTI)) begin errors++; $display("FAIL rst_mid_rti: got %h expected %h", tap_state, 4'(RTI)); end
        checks++; if (ir_value !== 5'h01) begin errors++; $display("FAIL rst_mid_ir: got %h expected 01", ir_value); end
        checks++; if ({jtag_TDO_data, jtag_TDO_driven, user_capture_strobe, user_update_valid} !== 4'b0) begin errors++; $display("FAIL rst_mid_outputs: got %b expected 0000", {jtag_TDO_data, jtag_TDO_driven, user_capture_strobe, user_update_valid}); end
        checks++; if (user_update_data !== 32'h0) begin errors++; $display("FAIL rst_mid_update_data: got %h expected 0", user_update_data); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL rst_mid_no_update: got %0d pulses expected 0", valid_cnt - v0); end
    endtask

    task automatic test_tck_hold();
        logic [31:0] d;
        int u;
        goto_shift_dr();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            jtag_TMS = i[0];
            jtag_TDI = ~i[1];
        end
        repeat (3) @(negedge clock);
        checks++; if (tap_state !== 4'(SHIFT_DR)) begin errors++; $display("FAIL hold_state: got %h expected %h", tap_state, 4'(SHIFT_DR)); end
        checks++; if (jtag_TDO_data !== 1'b1 || jtag_TDO_driven !== 1'b1) begin errors++; $display("FAIL hold_tdo: got %b%b expected 11", jtag_TDO_data, jtag_TDO_driven); end
        shift(32, 32'h0, 1'b1, d, u);
        checks++; if (d !== 32'h20000913) begin errors++; $display("FAIL hold_shift_reg: got %h expected 20000913", d); end
        exit_update();
        checks++; if (tap_state !== 4'(RTI)) begin errors++; $display("FAIL hold_back_rti: got %h expected %h", tap_state, 4'(RTI)); end
    endtask

    initial begin
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        test_reset();
        test_idcode();
        test_bypass();
        test_user_dr();
        test_trst_mid_shift();
        test_reset_mid_shift();
        test_tck_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
